// File: rtl/divisor_pkg.sv
// Shared mode codes, FSM states and enable helpers
// for the clock-division controller.
package divisor_pkg;

   localparam logic [1:0] MODO_DESL   = 2'b00;
   localparam logic [1:0] MODO_A      = 2'b01;
   localparam logic [1:0] MODO_B      = 2'b10;
   localparam logic [1:0] MODO_RAPIDO = 2'b11;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ATIVO    = 2'd1,
      PENDENTE = 2'd2
   } estado_t;

   function automatic logic habilita_rapido(
      input logic [1:0] m
   );
      return m != MODO_DESL;
   endfunction

   function automatic logic habilita_lento(
      input logic [1:0] m
   );
      return (m == MODO_A) || (m == MODO_B);
   endfunction

endpackage

// File: rtl/controlador_de_divisao_filtro.sv
// Two-flop synchroniser plus stability filter;
// aceito strobes once per value that holds ESTAVEL cycles.
module sincronizador_filtro #(
   parameter int WIDTH   = 2,
   parameter int ESTAVEL = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] entrada,
   output logic [WIDTH-1:0] valor,
   output logic             aceito
);

   localparam int CW = $clog2(ESTAVEL + 1);
   localparam logic [CW-1:0] ALVO = CW'(ESTAVEL);
   localparam logic [CW-1:0] UM   = CW'(1);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] ultimo;
   logic [CW-1:0]    cont;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1     <= '0;
         s2     <= '0;
         ultimo <= '0;
         cont   <= '0;
         valor  <= '0;
         aceito <= 1'b0;
      end else begin
         s1     <= entrada;
         s2     <= s1;
         aceito <= 1'b0;
         // cont saturates at ALVO so a held value fires only once
         if (s2 != ultimo) begin
            ultimo <= s2;
            cont   <= UM;
            if (UM == ALVO) begin
               aceito <= 1'b1;
               valor  <= s2;
            end
         end else if (cont != ALVO) begin
            cont <= cont + UM;
            if (cont + UM == ALVO) begin
               aceito <= 1'b1;
               valor  <= ultimo;
            end
         end
      end
   end

endmodule

// File: rtl/controlador_de_divisao.sv
// Fast/slow square-wave generator whose mode follows
// filtered switches, switching only on slow boundaries.
module controlador_de_divisao
   import divisor_pkg::*;
#(
   parameter int DIV_RAPIDO = 32,
   parameter int DIV_LENTO  = 16777216,
   parameter int ESTAVEL    = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ch1,
   input  logic       ch0,
   output logic       saida1,
   output logic       saida2,
   output logic       tick1,
   output logic       tick2,
   output logic [1:0] modo_atual,
   output logic       pendente
);

   localparam int WR = $clog2(DIV_RAPIDO);
   localparam int WL = $clog2(DIV_LENTO);
   localparam logic [WR-1:0] MAX_R  = WR'(DIV_RAPIDO - 1);
   localparam logic [WR-1:0] MEIO_R = WR'(DIV_RAPIDO / 2);
   localparam logic [WL-1:0] MAX_L  = WL'(DIV_LENTO - 1);
   localparam logic [WL-1:0] MEIO_L = WL'(DIV_LENTO / 2);

   logic [1:0]    valor;
   logic          aceito;
   estado_t       estado, estado_n;
   logic [1:0]    modo_n, pend, pend_n, alvo;
   logic          pendente_n, fim_l;
   logic [WR-1:0] cnt_r, cnt_r_n;
   logic [WL-1:0] cnt_l, cnt_l_n;
   logic          saida1_n, saida2_n;
   logic          tick1_n, tick2_n;

   sincronizador_filtro #(
      .WIDTH   (2),
      .ESTAVEL (ESTAVEL)
   ) u_filtro (
      .clk     (clk),
      .rst_n   (rst_n),
      .entrada ({ch1, ch0}),
      .valor   (valor),
      .aceito  (aceito)
   );

   always_comb begin
      estado_n   = estado;
      modo_n     = modo_atual;
      pend_n     = pend;
      pendente_n = pendente;
      alvo       = aceito ? valor : pend;
      fim_l      = (cnt_l == MAX_L);
      unique case (estado)
         OCIOSO: begin
            if (aceito && valor != MODO_DESL) begin
               modo_n   = valor;
               estado_n = ATIVO;
            end
         end
         ATIVO: begin
            if (aceito && valor != modo_atual) begin
               pend_n     = valor;
               pendente_n = 1'b1;
               estado_n   = PENDENTE;
            end
         end
         PENDENTE: begin
            // a fresh acceptance on the boundary wins
            if (fim_l) begin
               modo_n     = alvo;
               pendente_n = 1'b0;
               estado_n   = (alvo == MODO_DESL) ?
                            OCIOSO : ATIVO;
            end else if (aceito && valor == modo_atual) begin
               pendente_n = 1'b0;
               estado_n   = ATIVO;
            end else if (aceito) begin
               pend_n = valor;
            end
         end
         default: begin
            estado_n   = OCIOSO;
            modo_n     = MODO_DESL;
            pendente_n = 1'b0;
         end
      endcase

      // counters restart from 0 on activation; held while off
      if (modo_n == MODO_DESL || modo_atual == MODO_DESL) begin
         cnt_r_n = '0;
         cnt_l_n = '0;
      end else begin
         cnt_r_n = (cnt_r == MAX_R) ? '0 : cnt_r + WR'(1);
         cnt_l_n = (cnt_l == MAX_L) ? '0 : cnt_l + WL'(1);
      end

      saida1_n = habilita_rapido(modo_n) && (cnt_r_n >= MEIO_R);
      tick1_n  = habilita_rapido(modo_n) && (cnt_r_n == MAX_R);
      saida2_n = habilita_lento(modo_n) && (cnt_l_n >= MEIO_L);
      tick2_n  = habilita_lento(modo_n) && (cnt_l_n == MAX_L);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado     <= OCIOSO;
         modo_atual <= MODO_DESL;
         pend       <= MODO_DESL;
         pendente   <= 1'b0;
         cnt_r      <= '0;
         cnt_l      <= '0;
         saida1     <= 1'b0;
         saida2     <= 1'b0;
         tick1      <= 1'b0;
         tick2      <= 1'b0;
      end else begin
         estado     <= estado_n;
         modo_atual <= modo_n;
         pend       <= pend_n;
         pendente   <= pendente_n;
         cnt_r      <= cnt_r_n;
         cnt_l      <= cnt_l_n;
         saida1     <= saida1_n;
         saida2     <= saida2_n;
         tick1      <= tick1_n;
         tick2      <= tick2_n;
      end
   end

endmodule

// File: tb/tb_controlador_de_divisao.sv
// Directed plus random bench against a cycle-count
// reference model of the division controller.
module tb_controlador_de_divisao;

   localparam int DR = 4;
   localparam int DL = 16;
   localparam int E  = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] ch;
   logic       saida1, saida2, tick1, tick2;
   logic [1:0] modo_atual;
   logic       pendente;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [1:0] m_modo, m_pend, m_s1, m_s2, m_last, m_val;
   logic       m_tem, m_acc;
   int         m_n, m_run;

   always #5 clk = ~clk;

   controlador_de_divisao #(
      .DIV_RAPIDO (DR),
      .DIV_LENTO  (DL),
      .ESTAVEL    (E)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ch1        (ch[1]),
      .ch0        (ch[0]),
      .saida1     (saida1),
      .saida2     (saida2),
      .tick1      (tick1),
      .tick2      (tick2),
      .modo_atual (modo_atual),
      .pendente   (pendente)
   );

   task automatic modelo();
      logic fronteira, tinha;
      if (!rst_n) begin
         m_modo = 2'b00; m_pend = 2'b00; m_tem = 1'b0;
         m_n = 0; m_s1 = 2'b00; m_s2 = 2'b00;
         m_last = 2'b00; m_run = 0;
         m_acc = 1'b0; m_val = 2'b00;
      end else begin
         if (m_modo == 2'b00) begin
            if (m_acc && m_val != 2'b00) begin
               m_modo = m_val;
               m_n = 0;
            end
         end else begin
            fronteira = (m_n % DL == DL - 1);
            tinha = m_tem;
            if (m_acc) begin
               if (m_val != m_modo) begin
                  m_pend = m_val;
                  m_tem = 1'b1;
               end else begin
                  m_tem = 1'b0;
               end
            end
            if (tinha && fronteira && m_tem) begin
               m_modo = m_pend;
               m_tem = 1'b0;
            end
            if (m_modo == 2'b00) m_n = 0;
            else m_n = m_n + 1;
         end
         // acceptance = value seen for E consecutive samples
         if (m_s2 == m_last) begin
            if (m_run < E) begin
               m_run = m_run + 1;
               m_acc = (m_run == E);
               if (m_acc) m_val = m_last;
            end else begin
               m_acc = 1'b0;
            end
         end else begin
            m_last = m_s2;
            m_run = 1;
            m_acc = (E == 1);
            if (m_acc) m_val = m_s2;
         end
         m_s2 = m_s1;
         m_s1 = ch;
      end
   endtask

   task automatic chk(input string tag,
                      input logic [1:0] obs,
                      input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h t=%0t",
                tag, obs, exp, $time);
      end
   endtask

   task automatic verifica();
      logic en1, en2;
      en1 = (m_modo != 2'b00);
      en2 = (m_modo == 2'b01) || (m_modo == 2'b10);
      chk("saida1", {1'b0, saida1},
          {1'b0, en1 && (m_n % DR >= DR / 2)});
      chk("tick1", {1'b0, tick1},
          {1'b0, en1 && (m_n % DR == DR - 1)});
      chk("saida2", {1'b0, saida2},
          {1'b0, en2 && (m_n % DL >= DL / 2)});
      chk("tick2", {1'b0, tick2},
          {1'b0, en2 && (m_n % DL == DL - 1)});
      chk("modo_atual", modo_atual, m_modo);
      chk("pendente", {1'b0, pendente}, {1'b0, m_tem});
   endtask

   task automatic ciclos(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         modelo();
         #1;
         verifica();
      end
   endtask

   initial begin
      int hold;
      rst_n = 1'b0;
      ch = 2'b11;
      modelo();
      // 1: reset held with switches at 11
      ciclos(5);
      rst_n = 1'b1;
      ch = 2'b00;
      ciclos(10);
      // 2: enable fast-only mode; 6-cycle latency
      ch = 2'b11;
      ciclos(5);
      chk("lat5", modo_atual, 2'b00);
      ciclos(1);
      chk("lat6", modo_atual, 2'b11);
      ciclos(20);
      // 3: request mode 01 at slow count 5
      for (int i = 0; i < 32; i++) begin
         if (m_n % DL == 5) break;
         ciclos(1);
      end
      ch = 2'b01;
      ciclos(40);
      // 4: switch off, then a 2-cycle glitch
      ch = 2'b00;
      ciclos(40);
      ch = 2'b11;
      ciclos(2);
      ch = 2'b00;
      ciclos(12);
      chk("glitch", modo_atual, 2'b00);
      // 5: pending request withdrawn, then off
      ch = 2'b01;
      ciclos(20);
      ch = 2'b11;
      ciclos(6);
      ch = 2'b01;
      ciclos(30);
      ch = 2'b00;
      ciclos(40);
      // 6: reset pulse while pending
      ch = 2'b10;
      ciclos(12);
      ch = 2'b11;
      ciclos(7);
      rst_n = 1'b0;
      ciclos(1);
      chk("rst_modo", modo_atual, 2'b00);
      rst_n = 1'b1;
      ciclos(10);
      // 7: random switch activity with rare resets
      for (int j = 0; j < 120; j++) begin
         ch = 2'($urandom);
         hold = (j % 2 == 0) ? $urandom_range(1, 6)
                             : $urandom_range(4, 40);
         if ($urandom_range(0, 29) == 0) begin
            rst_n = 1'b0;
            ciclos(1);
            rst_n = 1'b1;
         end
         ciclos(hold);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
